// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : rv32 instruction-fetch stage. Holds the PC, addresses the
//               combinational instruction memory, and buffers each fetched
//               {pc, instr} pair in a small FIFO. Decode reads the FIFO over a
//               valid/ready handshake. A redirect reloads the PC and flushes
//               the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [1:0]  o_fault
);

  // Pointer width; count needs one extra bit to represent "full".
  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              CW         = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [31:0]     NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0]     IMEM_LIMIT = 32'(IMEM_WORDS);

  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [1:0]    fault;
  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic [31:0]   buf_pc    [FIFO_DEPTH];

  logic          pop;
  logic          push;
  logic          in_range;
  logic [31:0]   fetch_instr;

  // Word address straight from the held PC; the memory answers in the same cycle.
  assign o_imem_addr = {2'b00, pc[31:2]};
  assign in_range    = o_imem_addr < IMEM_LIMIT;
  // Fetches beyond the memory are replaced with a NOP so decode sees harmless code.
  assign fetch_instr = in_range ? i_imem_data : NOP_INSTR;

  assign o_valid = (count != '0);
  assign pop     = o_valid & i_ready;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push    = !i_redirect & ((count < DEPTH_C) | pop);

  assign o_instr = buf_instr[rd_ptr];
  assign o_pc    = buf_pc[rd_ptr];
  assign o_fault = fault;

  // PC, occupancy, pointers and sticky faults; redirect outranks fetching.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc     <= {RESET_PC[31:2], 2'b00};
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fault  <= 2'b00;
    end else if (i_redirect) begin
      pc     <= {i_redirect_pc[31:2], 2'b00};
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      if (i_redirect_pc[1:0] != 2'b00) begin
        fault[0] <= 1'b1;
      end
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
        if (!in_range) begin
          fault[1] <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Buffer storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= fetch_instr;
      buf_pc[wr_ptr]    <= pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Self-checking bench for if_fetch. A per-cycle vector table
//               drives reset/ready/redirect and checks the registered view of
//               the stage after each edge; a scoreboard queue holds the
//               expected instruction stream and is compared on every
//               completed handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [1:0]  fault;

  int checks = 0;
  int errors = 0;

  if_fetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2),
    .IMEM_WORDS (1024)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_addr   (imem_addr),
    .i_imem_data   (imem_data),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_instr       (instr),
    .o_pc          (pc),
    .o_fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: 1024 tagged words; outside that the bus returns junk.
  assign imem_data = (imem_addr < 32'd1024) ? (32'hA500_0000 | imem_addr) : 32'hFFFF_FFFF;

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic [1:0]  exp_fault;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  vec_t vq[$];
  ent_t sb[$];

  function automatic logic [31:0] exp_instr(input logic [31:0] p);
    logic [31:0] w;
    w = p >> 2;
    if (w < 32'd1024) return 32'hA500_0000 | w;
    return 32'h0000_0013;
  endfunction

  task automatic add(input logic r, input logic rd, input logic rdr, input logic [31:0] rp,
                     input logic ev, input logic [31:0] ep, input logic [31:0] ea,
                     input logic [1:0] ef);
    vec_t t;
    t.rst_n = r; t.ready = rd; t.redir = rdr; t.rpc = rp;
    t.exp_valid = ev; t.exp_pc = ep; t.exp_addr = ea; t.exp_fault = ef;
    vq.push_back(t);
  endtask

  task automatic chk(input int row, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row%0d %s actual=%h expected=%h", row, name, act, exp);
    end
  endtask

  // Expected stream after a reset or redirect: sequential words from the target.
  task automatic reload(input logic [31:0] start);
    ent_t e;
    logic [31:0] p;
    sb.delete();
    p = {start[31:2], 2'b00};
    for (int k = 0; k < 16; k++) begin
      e.pc    = p;
      e.instr = exp_instr(p);
      sb.push_back(e);
      p = p + 32'd4;
    end
  endtask

  initial begin
    vec_t v;
    ent_t e;
    rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    //   rst rdy rdr rpc           valid pc            addr          fault
    // Reset state
    add(0, 0, 0, 32'h0,         0, 32'h0,     32'h0,     2'b00);
    add(0, 0, 0, 32'h0,         0, 32'h0,     32'h0,     2'b00);
    // Release with decode ready: stream 0,4,8,12
    add(1, 1, 0, 32'h0,         1, 32'h0,     32'h1,     2'b00);
    add(1, 1, 0, 32'h0,         1, 32'h4,     32'h2,     2'b00);
    add(1, 1, 0, 32'h0,         1, 32'h8,     32'h3,     2'b00);
    add(1, 1, 0, 32'h0,         1, 32'hC,     32'h4,     2'b00);
    // Restart with decode stalled 5 cycles: buffer fills, fetch freezes at 2
    add(0, 0, 0, 32'h0,         0, 32'h0,     32'h0,     2'b00);
    add(1, 0, 0, 32'h0,         1, 32'h0,     32'h1,     2'b00);
    add(1, 0, 0, 32'h0,         1, 32'h0,     32'h2,     2'b00);
    add(1, 0, 0, 32'h0,         1, 32'h0,     32'h2,     2'b00);
    add(1, 0, 0, 32'h0,         1, 32'h0,     32'h2,     2'b00);
    add(1, 0, 0, 32'h0,         1, 32'h0,     32'h2,     2'b00);
    add(1, 1, 0, 32'h0,         1, 32'h4,     32'h3,     2'b00);
    add(1, 1, 0, 32'h0,         1, 32'h8,     32'h4,     2'b00);
    // Redirect to 0x20 with full buffer and a same-cycle pop: one bubble
    add(1, 1, 1, 32'h20,        0, 32'h0,     32'h8,     2'b00);
    add(1, 1, 0, 32'h0,         1, 32'h20,    32'h9,     2'b00);
    add(1, 1, 0, 32'h0,         1, 32'h24,    32'hA,     2'b00);
    // Misaligned redirect 0x22: fault[0], resume at 0x20
    add(1, 1, 1, 32'h22,        0, 32'h0,     32'h8,     2'b01);
    add(1, 1, 0, 32'h0,         1, 32'h20,    32'h9,     2'b01);
    // Redirect to last word, then run off the end of memory
    add(1, 1, 1, 32'hFFC,       0, 32'h0,     32'h3FF,   2'b01);
    add(1, 1, 0, 32'h0,         1, 32'hFFC,   32'h400,   2'b01);
    add(1, 1, 0, 32'h0,         1, 32'h1000,  32'h401,   2'b11);
    add(1, 1, 0, 32'h0,         1, 32'h1004,  32'h402,   2'b11);
    // Fill the buffer, then reset mid-stream
    add(1, 0, 0, 32'h0,         1, 32'h1004,  32'h403,   2'b11);
    add(1, 0, 0, 32'h0,         1, 32'h1004,  32'h403,   2'b11);
    add(0, 0, 0, 32'h0,         0, 32'h0,     RESET_PC >> 2, 2'b00);
    add(1, 1, 0, 32'h0,         1, RESET_PC,  (RESET_PC >> 2) + 32'd1, 2'b00);
    add(1, 1, 0, 32'h0,         1, RESET_PC + 32'd4, (RESET_PC >> 2) + 32'd2, 2'b00);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      rst_n       = v.rst_n;
      ready       = v.ready;
      redirect    = v.redir;
      redirect_pc = v.rpc;
      #1;
      // Completed handshake this cycle: compare head against the expected stream.
      if (v.rst_n && v.ready && valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk(i, "sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk(i, "sb_pc", pc, e.pc);
          chk(i, "sb_instr", instr, e.instr);
        end
      end
      if (!v.rst_n) reload(RESET_PC);
      else if (v.redir) reload(v.rpc);
      @(posedge clk);
      #1;
      chk(i, "valid", {31'd0, valid}, {31'd0, v.exp_valid});
      chk(i, "imem_addr", imem_addr, v.exp_addr);
      chk(i, "fault", {30'd0, fault}, {30'd0, v.exp_fault});
      if (v.exp_valid) begin
        chk(i, "pc", pc, v.exp_pc);
        chk(i, "instr", instr, exp_instr(v.exp_pc));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
